// File: rtl/four_bit_sequencer_if.sv
// Control/instruction bundle between the sequencer (master) and the 4-bit datapath (slave).
interface four_bit_sequencer_if;
  logic       SingleStep;
  logic       ButtonForSingleStep;
  logic [7:0] OpCode;
  logic [1:0] RdAddrX;
  logic [1:0] RdAddrY;
  logic [1:0] WrAddr;
  logic       WrEn;
  logic [1:0] WrDataSel;
  logic [3:0] Imm;
  logic [1:0] AluSel;
  logic       StoreEn;
  logic       Busy;
  logic       InstrDone;

  modport master (
    input  SingleStep, ButtonForSingleStep, OpCode,
    output RdAddrX, RdAddrY, WrAddr, WrEn, WrDataSel, Imm, AluSel, StoreEn, Busy, InstrDone
  );

  modport slave (
    output SingleStep, ButtonForSingleStep, OpCode,
    input  RdAddrX, RdAddrY, WrAddr, WrEn, WrDataSel, Imm, AluSel, StoreEn, Busy, InstrDone
  );
endinterface

// File: rtl/four_bit_sequencer.sv
// Four-state (IDLE/DECODE/EXEC/WB) control unit for the 4-bit datapath.
// Define SEQ_BUTTON_DEBOUNCE_EN to debounce the single-step button.
module four_bit_sequencer
`ifdef SEQ_BUTTON_DEBOUNCE_EN
  #(parameter int unsigned DEBOUNCE_CYCLES = 4)
`endif
(
  input logic                  Clock,
  input logic                  Reset,
  four_bit_sequencer_if.master bus
);

  typedef enum logic [1:0] {StIdle, StDecode, StExec, StWb} stateT;

  stateT      stateQ, stateD;
  logic [7:0] irQ, irD;
  logic       sync0Q, sync1Q;
  logic       stepPulse;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      stateQ <= StIdle;
      irQ    <= 8'h00;
      sync0Q <= 1'b1;
      sync1Q <= 1'b1;
    end else begin
      stateQ <= stateD;
      irQ    <= irD;
      sync0Q <= bus.ButtonForSingleStep;
      sync1Q <= sync0Q;
    end
  end

`ifdef SEQ_BUTTON_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CntW-1:0] cntQ;

  // Saturates at DEBOUNCE_CYCLES so a held button yields a single pulse.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cntQ <= '0;
    end else if (sync1Q) begin
      cntQ <= '0;
    end else if (cntQ != CntW'(DEBOUNCE_CYCLES)) begin
      cntQ <= cntQ + 1'b1;
    end
  end

  assign stepPulse = !sync1Q && (cntQ == CntW'(DEBOUNCE_CYCLES - 1));
`else
  logic prevQ;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      prevQ <= 1'b1;
    end else begin
      prevQ <= sync1Q;
    end
  end

  assign stepPulse = !sync1Q && prevQ;
`endif

  always_comb begin
    stateD        = stateQ;
    irD           = irQ;
    bus.RdAddrX   = 2'd0;
    bus.RdAddrY   = 2'd0;
    bus.WrAddr    = 2'd0;
    bus.WrEn      = 1'b0;
    bus.WrDataSel = 2'd0;
    bus.Imm       = 4'd0;
    bus.AluSel    = 2'd0;
    bus.StoreEn   = 1'b0;
    bus.Busy      = (stateQ != StIdle);
    bus.InstrDone = (stateQ == StWb);

    // Presses arriving outside IDLE are simply dropped.
    unique case (stateQ)
      StIdle: begin
        if (bus.SingleStep || stepPulse) begin
          stateD = StDecode;
          irD    = bus.OpCode;
        end
      end
      StDecode: stateD = StExec;
      StExec:   stateD = StWb;
      StWb:     stateD = StIdle;
      default:  stateD = StIdle;
    endcase

    if (stateQ != StIdle) begin
      unique case (irQ[7:6])
        2'b00: begin
          bus.WrAddr    = irQ[5:4];
          bus.Imm       = irQ[3:0];
          bus.WrDataSel = 2'd0;
          bus.WrEn      = (stateQ == StWb);
        end
        2'b01: begin
          bus.RdAddrX = irQ[5:4];
          bus.StoreEn = (stateQ == StWb);
        end
        2'b10: begin
          bus.WrAddr    = irQ[5:4];
          bus.RdAddrY   = irQ[3:2];
          bus.WrDataSel = 2'd1;
          bus.WrEn      = (stateQ == StWb);
        end
        default: begin
          bus.RdAddrX   = irQ[5:4];
          bus.WrAddr    = irQ[5:4];
          bus.RdAddrY   = irQ[3:2];
          bus.AluSel    = irQ[1:0];
          bus.WrDataSel = 2'd2;
          bus.WrEn      = (stateQ == StWb);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_four_bit_sequencer.sv
// Randomized bench for four_bit_sequencer against a cycle-level behavioural model.
module tb_four_bit_sequencer;

  logic clock;
  logic reset;

  four_bit_sequencer_if bus ();

  four_bit_sequencer dut (
    .Clock (clock),
    .Reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef SEQ_BUTTON_DEBOUNCE_EN
  localparam int Db       = 4;
  localparam int PressLen = 6;
`else
  localparam int PressLen = 1;
`endif

  int nChecks = 0;
  int nFails  = 0;

  // Model: sampled button history (bit 0 newest), phase 0 = idle, 1..3 = busy.
  logic [15:0] hist;
  int          mPhase;
  logic [7:0]  mIr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic pulseNow(input logic [15:0] h);
`ifdef SEQ_BUTTON_DEBOUNCE_EN
    logic allLow = 1'b1;
    for (int i = 1; i <= Db; i++) allLow = allLow & !h[i];
    return allLow && h[Db+1];
`else
    return !h[1] && h[2];
`endif
  endfunction

  // Packs {RdAddrX, RdAddrY, WrAddr, WrEn, WrDataSel, Imm, AluSel, StoreEn, Busy, InstrDone}.
  function automatic logic [31:0] expVec(input int phase, input logic [7:0] ir);
    logic [1:0] rx, ry, wa, sel, alu;
    logic [3:0] imm;
    logic       we, se;
    rx = 0; ry = 0; wa = 0; sel = 0; alu = 0; imm = 0; we = 0; se = 0;
    if (phase != 0) begin
      case (ir[7:6])
        2'd0: begin wa = ir[5:4]; imm = ir[3:0]; we = (phase == 3); end
        2'd1: begin rx = ir[5:4]; se = (phase == 3); end
        2'd2: begin wa = ir[5:4]; ry = ir[3:2]; sel = 2'd1; we = (phase == 3); end
        default: begin
          rx = ir[5:4]; wa = ir[5:4]; ry = ir[3:2]; alu = ir[1:0]; sel = 2'd2;
          we = (phase == 3);
        end
      endcase
    end
    return {14'd0, rx, ry, wa, we, sel, imm, alu, se, (phase != 0), (phase == 3)};
  endfunction

  function automatic logic [31:0] dutVec();
    return {14'd0, bus.RdAddrX, bus.RdAddrY, bus.WrAddr, bus.WrEn, bus.WrDataSel, bus.Imm,
            bus.AluSel, bus.StoreEn, bus.Busy, bus.InstrDone};
  endfunction

  task automatic modelReset();
    hist   = '1;
    mPhase = 0;
    mIr    = 8'h00;
  endtask

  task automatic cycle();
    @(posedge clock);
    if (!reset) begin
      modelReset();
    end else begin
      if (mPhase == 0) begin
        if (bus.SingleStep || pulseNow(hist)) begin
          mPhase = 1;
          mIr    = bus.OpCode;
        end
      end else begin
        mPhase = (mPhase == 3) ? 0 : mPhase + 1;
      end
      hist = {hist[14:0], bus.ButtonForSingleStep};
    end
    @(negedge clock);
    chk("outs", dutVec(), expVec(mPhase, mIr));
  endtask

  task automatic press(input logic [7:0] op, input int lowCycles);
    bus.OpCode = op;
    bus.ButtonForSingleStep = 1'b0;
    repeat (lowCycles) cycle();
    bus.ButtonForSingleStep = 1'b1;
    // Scrambling OpCode after issue must not disturb the running instruction.
    repeat (9) begin
      cycle();
      if (mPhase != 0) bus.OpCode = 8'($urandom);
    end
  endtask

  logic [7:0] dirOps [5] = '{8'b00010010, 8'b11011000, 8'b11000101, 8'b01110000, 8'b10001100};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    bus.SingleStep = 1'b0;
    bus.ButtonForSingleStep = 1'b1;
    bus.OpCode = 8'h00;
    modelReset();
    repeat (3) cycle();
    reset = 1'b1;
    repeat (10) cycle();

    foreach (dirOps[i]) press(dirOps[i], PressLen);

    // Long hold, then a second press landing while busy.
    bus.ButtonForSingleStep = 1'b0;
    repeat (50) begin bus.OpCode = 8'($urandom); cycle(); end
    bus.ButtonForSingleStep = 1'b1;
    repeat (2) cycle();
    bus.ButtonForSingleStep = 1'b0;
    repeat (PressLen) cycle();
    bus.ButtonForSingleStep = 1'b1;
    cycle();
    bus.ButtonForSingleStep = 1'b0;
    repeat (PressLen) cycle();
    bus.ButtonForSingleStep = 1'b1;
    repeat (10) cycle();

    press(8'($urandom), 2);
    press(8'($urandom), 6);

    bus.SingleStep = 1'b1;
    repeat (20) begin bus.OpCode = 8'($urandom); cycle(); end

    for (int i = 0; i < 400; i++) begin
      if (i % 25 == 0) bus.SingleStep = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) bus.ButtonForSingleStep = ~bus.ButtonForSingleStep;
      bus.OpCode = 8'($urandom);
      cycle();
    end

    // Asynchronous reset during EXEC of a LOADI.
    bus.SingleStep = 1'b0;
    bus.ButtonForSingleStep = 1'b1;
    repeat (8) cycle();
    bus.OpCode = 8'h27;
    bus.ButtonForSingleStep = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == PressLen) bus.ButtonForSingleStep = 1'b1;
      if (mPhase == 2) break;
      cycle();
    end
    bus.ButtonForSingleStep = 1'b1;
    chk("busyAtExec", 32'(bus.Busy), 32'd1);
    #2;
    reset = 1'b0;
    modelReset();
    #1;
    chk("rstAsyncWrEn", 32'(bus.WrEn), 32'd0);
    chk("rstAsyncBusy", 32'(bus.Busy), 32'd0);
    repeat (3) cycle();
    reset = 1'b1;
    repeat (10) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
